inst_fetch_queue: RTL

- Parametrised prefetch FIFO between the IF stage (pc_reg + instruction ROM) and the ID stage.
- Replaces the single-entry IF/ID pipeline register with a DEPTH-entry queue of {pc, inst} pairs.
- Fetch can run ahead while ID is stalled.
- Branch redirect from ID flushes all queued entries.

---
 rtl/inst_fetch_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module   : inst_fetch_queue
// Purpose  : DEPTH-entry show-ahead prefetch FIFO of {pc, inst} pairs sitting
//            between the IF and ID stages; a redirect from ID flushes it.
//            Optional macro FQ_BYPASS_EN adds a zero-latency empty bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid_i,
  input  logic [ADDR_W-1:0]          fetch_pc_i,
  input  logic [DATA_W-1:0]          fetch_inst_i,
  output logic                       fetch_ready_o,
  output logic                       id_valid_o,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [DATA_W-1:0]          id_inst_o,
  input  logic                       id_ready_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [ADDR_W-1:0]  r_pc_mem   [DEPTH];
  logic [DATA_W-1:0]  r_inst_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_bypass;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_CNT_W'(DEPTH));

`ifdef FQ_BYPASS_EN
  // Gated by rst so the outputs stay quiet while reset is held.
  assign w_bypass = rst & w_empty & fetch_valid_i & id_ready_i & ~flush_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = fetch_valid_i & ~w_full & ~flush_i & ~w_bypass;
  assign w_pop  = ~w_empty & id_ready_i & ~flush_i;

  assign fetch_ready_o = ~w_full;
  assign count_o       = r_count;

  // Show-ahead head; zero when nothing valid so ID sees a NOP.
  always_comb begin
    id_valid_o = 1'b0;
    id_pc_o    = '0;
    id_inst_o  = '0;
    if (!w_empty) begin
      id_valid_o = 1'b1;
      id_pc_o    = r_pc_mem[r_rd_ptr];
      id_inst_o  = r_inst_mem[r_rd_ptr];
    end else if (w_bypass) begin
      id_valid_o = 1'b1;
      id_pc_o    = fetch_pc_i;
      id_inst_o  = fetch_inst_i;
    end
  end

  // Storage has no reset: contents are only observed through a valid count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= fetch_pc_i;
      r_inst_mem[r_wr_ptr] <= fetch_inst_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire
